// File: rtl/peripheral_input_conditioner.sv
// -----------------------------------------------------------------------------
// peripheral_input_conditioner
//
// Purpose
//   Conditions a bouncing push-button and an 8-bit slide-switch bank for the
//   operand-entry stage. Both raw inputs are first brought into the clk domain
//   through two-flop synchronizers. A five-state FSM then debounces the button
//   on press and on release. Each accepted press produces a one-cycle strobe
//   together with the switch byte captured on that same edge. A press held long
//   enough also produces a one-cycle long-press strobe.
//
// Parameters
//   DEBOUNCE_CYCLES    stable synchronized cycles needed to accept a press or
//                      a release (2..65535)
//   LONG_PRESS_CYCLES  held cycles after acceptance before the long-press
//                      strobe (3..65535, greater than DEBOUNCE_CYCLES)
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   enter_raw     in   raw push-button level, active-high, asynchronous
//   switches_raw  in   raw slide-switch byte, asynchronous
//   pulse         out  one-cycle strobe for each accepted press
//   data_out      out  synchronized switch byte captured with the accepted press
//   long_pulse    out  one-cycle strobe once a press has been held long enough
//   press_count   out  number of accepted presses, modulo 256
//   busy          out  high whenever the FSM is outside IDLE
//   state_dbg     out  current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module peripheral_input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES   = 4,
   parameter int unsigned LONG_PRESS_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enter_raw,
   input  logic [7:0] switches_raw,
   output logic       pulse,
   output logic [7:0] data_out,
   output logic       long_pulse,
   output logic [7:0] press_count,
   output logic       busy,
   output logic [2:0] state_dbg
);

   // Terminal counts for the shared counter.
   localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
   localparam logic [15:0] LONG_LAST = 16'(LONG_PRESS_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_DEB_PRESS   = 3'd1,
      ST_PRESSED     = 3'd2,
      ST_HELD_LONG   = 3'd3,
      ST_DEB_RELEASE = 3'd4
   } state_e;

   // ---------------------------------------------------------------------------
   // Input synchronizers. The switch byte is synchronized bit by bit. The byte is
   // only sampled after the button has been stable for several cycles, and the
   // operator holds the switches still while pressing, so bits arriving in
   // different cycles settle long before the capture edge.
   // ---------------------------------------------------------------------------
   logic       enter_meta_q;
   logic       enter_s_q;
   logic [7:0] switches_meta_q;
   logic [7:0] switches_s_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         enter_meta_q    <= 1'b0;
         enter_s_q       <= 1'b0;
         switches_meta_q <= 8'h00;
         switches_s_q    <= 8'h00;
      end else begin
         enter_meta_q    <= enter_raw;
         enter_s_q       <= enter_meta_q;
         switches_meta_q <= switches_raw;
         switches_s_q    <= switches_meta_q;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM state and datapath registers.
   // ---------------------------------------------------------------------------
   state_e      state_q,  state_d;
   logic [15:0] cnt_q,    cnt_d;
   logic        pulse_q,  pulse_d;
   logic        long_q,   long_d;
   logic [7:0]  data_q,   data_d;
   logic [7:0]  count_q,  count_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 16'd0;
         pulse_q <= 1'b0;
         long_q  <= 1'b0;
         data_q  <= 8'h00;
         count_q <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
         long_q  <= long_d;
         data_q  <= data_d;
         count_q <= count_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and strobe logic. Each strobe is set only on the transition
   // out of the state that produces it, so it is exactly one cycle wide. Those
   // transitions are different edges, so pulse and long_pulse can never be
   // high together.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      long_d  = 1'b0;
      data_d  = data_q;
      count_d = count_q;

      case (state_q)
         ST_IDLE: begin
            if (enter_s_q) begin
               state_d = ST_DEB_PRESS;
               cnt_d   = 16'd0;
            end
         end

         ST_DEB_PRESS: begin
            if (!enter_s_q) begin
               // A glitch that did not last long enough; drop it silently.
               state_d = ST_IDLE;
               cnt_d   = 16'd0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = ST_PRESSED;
               cnt_d   = 16'd0;
               pulse_d = 1'b1;
               data_d  = switches_s_q;
               count_d = count_q + 8'd1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         ST_PRESSED: begin
            if (!enter_s_q) begin
               state_d = ST_DEB_RELEASE;
               cnt_d   = 16'd0;
            end else if (cnt_q == LONG_LAST) begin
               state_d = ST_HELD_LONG;
               long_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         ST_HELD_LONG: begin
            // The counter is frozen here, so a single long hold strobes once.
            if (!enter_s_q) begin
               state_d = ST_DEB_RELEASE;
               cnt_d   = 16'd0;
            end
         end

         ST_DEB_RELEASE: begin
            if (enter_s_q) begin
               // Contact bounce while releasing: restart the stable-low count.
               // The press is not re-accepted, so no new pulse.
               cnt_d = 16'd0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = 16'd0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         default: begin
            // Unused encodings recover to IDLE without emitting a strobe.
            state_d = ST_IDLE;
            cnt_d   = 16'd0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs.
   // ---------------------------------------------------------------------------
   assign pulse       = pulse_q;
   assign long_pulse  = long_q;
   assign data_out    = data_q;
   assign press_count = count_q;
   assign busy        = (state_q != ST_IDLE);
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_peripheral_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_peripheral_input_conditioner
//
// Directed bench for peripheral_input_conditioner with DEBOUNCE_CYCLES=4 and
// LONG_PRESS_CYCLES=16. A reference model describes the button in terms of
// run lengths of the synchronized level:
//   - press accepted after D+1 consecutive high samples while released
//   - long press after L further high samples with no low sample
//   - release complete after D+1 lows, or after D lows following a bounce
// The model is compared against the DUT on every cycle. Directed checks pin
// the absolute cycle numbers of strobes and the literal output values.
// -----------------------------------------------------------------------------
module tb_peripheral_input_conditioner;

   localparam int D = 4;
   localparam int L = 16;

   // ---------------------------------------------------------------- clock/reset
   logic       clk          = 1'b0;
   logic       reset        = 1'b1;
   logic       enter_raw    = 1'b0;
   logic [7:0] switches_raw = 8'h00;

   logic       pulse;
   logic       long_pulse;
   logic       busy;
   logic [7:0] data_out;
   logic [7:0] press_count;
   logic [2:0] state_dbg;

   always #5 clk = ~clk;

   peripheral_input_conditioner #(
      .DEBOUNCE_CYCLES  (D),
      .LONG_PRESS_CYCLES(L)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enter_raw   (enter_raw),
      .switches_raw(switches_raw),
      .pulse       (pulse),
      .data_out    (data_out),
      .long_pulse  (long_pulse),
      .press_count (press_count),
      .busy        (busy),
      .state_dbg   (state_dbg)
   );

   // ---------------------------------------------------------------- scoring
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   logic       m_raw1 = 1'b0, m_raw2 = 1'b0;
   logic [7:0] m_sw1 = 8'h00, m_sw2 = 8'h00;
   bit         m_released    = 1'b1;
   int         m_hi_run      = 0;
   int         m_hold_run    = 0;
   int         m_lo_run      = 0;
   bit         m_rel_started = 1'b0;
   bit         m_bounced     = 1'b0;
   bit         m_long_done   = 1'b0;
   logic       m_pulse = 1'b0, m_long = 1'b0;
   logic [7:0] m_data = 8'h00, m_count = 8'h00;

   task automatic model_reset();
      m_raw1 = 1'b0; m_raw2 = 1'b0; m_sw1 = 8'h00; m_sw2 = 8'h00;
      m_released = 1'b1; m_hi_run = 0; m_hold_run = 0; m_lo_run = 0;
      m_rel_started = 1'b0; m_bounced = 1'b0; m_long_done = 1'b0;
      m_pulse = 1'b0; m_long = 1'b0; m_data = 8'h00; m_count = 8'h00;
   endtask

   task automatic model_step();
      logic       s;
      logic [7:0] sw;
      s  = m_raw2;
      sw = m_sw2;
      m_raw2 = m_raw1; m_raw1 = enter_raw;
      m_sw2  = m_sw1;  m_sw1  = switches_raw;
      m_pulse = 1'b0;
      m_long  = 1'b0;
      if (m_released) begin
         if (s) begin
            m_hi_run++;
            if (m_hi_run == D + 1) begin
               m_pulse = 1'b1;
               m_data  = sw;
               m_count = m_count + 8'd1;
               m_released = 1'b0;
               m_hi_run = 0; m_hold_run = 0; m_lo_run = 0;
               m_rel_started = 1'b0; m_bounced = 1'b0; m_long_done = 1'b0;
            end
         end else begin
            m_hi_run = 0;
         end
      end else if (s) begin
         if (m_rel_started) begin
            m_bounced = 1'b1;
            m_lo_run  = 0;
         end else begin
            m_hold_run++;
            if (m_hold_run == L && !m_long_done) begin
               m_long = 1'b1;
               m_long_done = 1'b1;
            end
         end
      end else begin
         m_rel_started = 1'b1;
         m_lo_run++;
         if (m_lo_run == (m_bounced ? D : D + 1)) begin
            m_released = 1'b1;
            m_hi_run = 0;
         end
      end
   endtask

   // ---------------------------------------------------------------- monitor
   int   cyc           = 0;
   int   n_pulse       = 0;
   int   n_long        = 0;
   int   pulse_cyc     = -1;
   int   long_cyc      = -1;
   int   busy_fall_cyc = -1;
   logic prev_busy     = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         if (reset) model_reset();
         else model_step();
         #2;
         cyc++;
         check("cyc_pulse", pulse, m_pulse);
         check("cyc_long_pulse", long_pulse, m_long);
         check("cyc_data_out", data_out, m_data);
         check("cyc_press_count", press_count, m_count);
         check("cyc_busy", busy, !(m_released && m_hi_run == 0));
         if (pulse) begin n_pulse++; pulse_cyc = cyc; end
         if (long_pulse) begin n_long++; long_cyc = cyc; end
         if (prev_busy && !busy) busy_fall_cyc = cyc;
         prev_busy = busy;
      end
   end

   // ---------------------------------------------------------------- driver
   task automatic wait_neg(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         p0, l0, c0, ca, cr;
      logic [7:0] sw;

      // Reset state
      wait_neg(3);
      check("rst_pulse", pulse, 1'b0);
      check("rst_long", long_pulse, 1'b0);
      check("rst_data", data_out, 8'h00);
      check("rst_count", press_count, 8'h00);
      check("rst_busy", busy, 1'b0);
      reset = 1'b0;
      wait_neg(2);

      // Short glitch: three high cycles are rejected
      p0 = n_pulse;
      enter_raw = 1'b1; wait_neg(3);
      enter_raw = 1'b0; wait_neg(10);
      check("glitch_pulses", n_pulse - p0, 0);
      check("glitch_count", press_count, 8'h00);
      check("glitch_busy", busy, 1'b0);

      // Clean press, A5: pulse after edge 6 only
      p0 = n_pulse;
      switches_raw = 8'hA5; enter_raw = 1'b1; c0 = cyc + 1;
      wait_neg(12);
      check("press_pulses", n_pulse - p0, 1);
      check("press_latency", pulse_cyc, c0 + 6);
      check("press_data", data_out, 8'hA5);
      check("press_count", press_count, 8'h01);
      // switch changes while held leave data_out alone
      switches_raw = 8'h3C; wait_neg(4);
      check("hold_data", data_out, 8'hA5);
      enter_raw = 1'b0; wait_neg(10);
      check("release_busy", busy, 1'b0);

      // Bouncing release: one pulse; IDLE 4 lows after the last bounce
      p0 = n_pulse;
      switches_raw = 8'h5A; enter_raw = 1'b1; wait_neg(12);
      ca = cyc + 1;
      enter_raw = 1'b0; wait_neg(1);
      enter_raw = 1'b1; wait_neg(1);
      enter_raw = 1'b0; wait_neg(1);
      enter_raw = 1'b1; wait_neg(1);
      enter_raw = 1'b0; wait_neg(12);
      check("bounce_pulses", n_pulse - p0, 1);
      check("bounce_idle_cyc", busy_fall_cyc, ca + 9);
      check("bounce_data", data_out, 8'h5A);
      check("bounce_count", press_count, 8'h02);

      // Long hold of 30 cycles: long pulse 16 cycles after pulse, only once
      p0 = n_pulse; l0 = n_long;
      switches_raw = 8'hC3; enter_raw = 1'b1; c0 = cyc + 1;
      wait_neg(30);
      enter_raw = 1'b0; wait_neg(12);
      check("long_pulses", n_pulse - p0, 1);
      check("long_count_ev", n_long - l0, 1);
      check("long_pulse_cyc", pulse_cyc, c0 + 6);
      check("long_gap", long_cyc - pulse_cyc, 16);
      check("long_press_count", press_count, 8'h03);

      // Reset two cycles into DEB_PRESS, enter held high through it
      switches_raw = 8'h77; enter_raw = 1'b1;
      wait_neg(5);
      check("mid_busy", busy, 1'b1);
      reset = 1'b1;
      #1;
      check("mid_rst_pulse", pulse, 1'b0);
      check("mid_rst_long", long_pulse, 1'b0);
      check("mid_rst_data", data_out, 8'h00);
      check("mid_rst_count", press_count, 8'h00);
      check("mid_rst_busy", busy, 1'b0);
      wait_neg(2);
      p0 = n_pulse; cr = cyc + 1;
      reset = 1'b0;
      wait_neg(10);
      check("post_rst_pulses", n_pulse - p0, 1);
      check("post_rst_latency", pulse_cyc, cr + 6);
      check("post_rst_data", data_out, 8'h77);
      check("post_rst_count", press_count, 8'h01);
      enter_raw = 1'b0; wait_neg(10);

      // 256 presses: counter wraps, data_out follows each press
      reset = 1'b1; wait_neg(2);
      reset = 1'b0; wait_neg(2);
      p0 = n_pulse;
      for (int i = 0; i < 256; i++) begin
         sw = 8'((i * 37) + 11);
         switches_raw = sw; enter_raw = 1'b1;
         wait_neg(9);
         check("wrap_data", data_out, sw);
         enter_raw = 1'b0;
         wait_neg(8);
         if (i == 254) check("wrap_count_ff", press_count, 8'hFF);
      end
      check("wrap_pulses", n_pulse - p0, 256);
      check("wrap_count_00", press_count, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
